work_loader: RTL and testbench



---
 rtl/work_pkg.sv | 16 +
 rtl/frame_timer.sv | 26 ++
 rtl/work_loader.sv | 93 +++++++++
 tb/tb_work_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/work_pkg.sv
// rtl/work_pkg.sv - shared widths, job field offsets and FSM state for work_loader
package work_pkg;
  localparam int WORD_W         = 32;
  localparam int DEFAULT_WORDS  = 11;
  localparam int MIDSTATE_WORDS = 8;
  localparam int TAIL_WORDS     = 3;
  localparam int MIDSTATE_LSB   = 0;
  localparam int MIDSTATE_BITS  = MIDSTATE_WORDS * WORD_W;
  localparam int TAIL_LSB       = MIDSTATE_LSB + MIDSTATE_BITS;
  localparam int TAIL_BITS      = TAIL_WORDS * WORD_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-word idle counter; expired flags the cycle the count reaches TIMEOUT_CYCLES-1
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !run || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/work_loader.sv
// rtl/work_loader.sv - assembles WORDS received words into one job held on a valid/ready output
// Optional stale-frame discard is built when WORK_LOADER_TIMEOUT_EN is defined.
module work_loader
  import work_pkg::*;
#(
  parameter int WORDS          = DEFAULT_WORDS,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ack,
  output logic [WORD_W*WORDS-1:0]      job_data,
  output logic                         job_valid,
  input  logic                         job_ready,
  output logic [$clog2(WORDS+1)-1:0]   fill_level,
  output logic                         frame_err
);
  localparam int FW = $clog2(WORDS + 1);

  state_t state;
  logic   accept;
  logic   expired;

  assign in_ack    = (state == FILL);
  assign job_valid = (state == HOLD);
  assign accept    = in_valid && (state == FILL);

`ifdef WORK_LOADER_TIMEOUT_EN
  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    ((state == FILL) && (fill_level != '0)),
    .clear  (accept),
    .expired(expired)
  );

  // A word arriving on the expiry cycle keeps the frame alive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= expired && !accept;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES >= 4000);
  assign expired        = 1'b0;
  assign frame_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_level <= '0;
      job_data   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < WORDS; k++) begin
              if (fill_level == FW'(k)) begin
                job_data[k*WORD_W +: WORD_W] <= in_data;
              end
            end
            if (fill_level == FW'(WORDS - 1)) begin
              state      <= HOLD;
              fill_level <= FW'(WORDS);
            end else begin
              fill_level <= fill_level + 1'b1;
            end
          end else if (expired) begin
            fill_level <= '0;
          end
        end
        HOLD: begin
          if (job_ready) begin
            state      <= FILL;
            fill_level <= '0;
          end
        end
        default: begin
          state      <= FILL;
          fill_level <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_work_loader.sv
// tb/tb_work_loader.sv - directed self-checking bench for work_loader (timeout test needs WORK_LOADER_TIMEOUT_EN)
module tb_work_loader;
  localparam int WORDS = 11;
  localparam int TO    = 4000;
  localparam int JW    = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ack;
  logic [JW-1:0] job_data;
  logic          job_valid;
  logic          job_ready = 1'b0;
  logic [3:0]    fill_level;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  work_loader #(.WORDS(WORDS), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .job_data  (job_data),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .fill_level(fill_level),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [JW-1:0] got, input logic [JW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [JW-1:0] make_job(input logic [31:0] base);
    logic [JW-1:0] j;
    for (int k = 0; k < WORDS; k++) j[32*k +: 32] = base + 32'(k);
    return j;
  endfunction

  task automatic send(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int jobs;
    int jv_cyc [2];
    int pulses;
    int pulse_at;
    logic [JW-1:0] exp_job;

    // reset state
    #1;
    check("rst_fill", JW'(fill_level), JW'(0));
    check("rst_job_valid", JW'(job_valid), JW'(0));
    check("rst_in_ack", JW'(in_ack), JW'(1));
    check("rst_job_data", job_data, '0);
    check("rst_frame_err", JW'(frame_err), JW'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // full frame against a stalled consumer
    send(32'h1, WORDS);
    check("ff_job_valid", JW'(job_valid), JW'(1));
    check("ff_in_ack", JW'(in_ack), JW'(0));
    check("ff_fill", JW'(fill_level), JW'(11));
    check("ff_word0", JW'(job_data[31:0]), JW'(32'h1));
    check("ff_word10", JW'(job_data[351:320]), JW'(32'hB));
    in_valid = 1'b1;
    in_data  = 32'hC;
    tick();
    check("ff_hold_fill", JW'(fill_level), JW'(11));
    check("ff_hold_data", job_data, make_job(32'h1));
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    check("ff_hs_job_valid", JW'(job_valid), JW'(0));
    check("ff_hs_fill", JW'(fill_level), JW'(0));
    check("ff_hs_in_ack", JW'(in_ack), JW'(1));
    tick();
    in_valid = 1'b0;
    check("ff_w12_fill", JW'(fill_level), JW'(1));
    check("ff_w12_slot0", JW'(job_data[31:0]), JW'(32'hC));

    // asynchronous reset mid-frame
    rst_n = 1'b0;
    #1;
    check("mr_fill", JW'(fill_level), JW'(0));
    check("mr_job_valid", JW'(job_valid), JW'(0));
    check("mr_in_ack", JW'(in_ack), JW'(1));
    check("mr_job_data", job_data, '0);
    check("mr_frame_err", JW'(frame_err), JW'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // back-to-back words with an always-ready consumer
    sent = 0;
    jobs = 0;
    jv_cyc[0] = -1;
    jv_cyc[1] = -1;
    job_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      logic acc;
      in_data = 32'h100 + 32'(sent);
      acc = in_ack;
      if (job_valid && jobs < 2) begin
        jv_cyc[jobs] = cyc;
        check($sformatf("b2b_job%0d", jobs), job_data, make_job(32'h100 + 32'(jobs * WORDS)));
        jobs++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    job_ready = 1'b0;
    check("b2b_jv_cycle0", JW'(jv_cyc[0]), JW'(11));
    check("b2b_jv_cycle1", JW'(jv_cyc[1]), JW'(23));
    check("b2b_sent", JW'(sent), JW'(22));
    check("b2b_fill_end", JW'(fill_level), JW'(0));

`ifdef WORK_LOADER_TIMEOUT_EN
    // timeout discards a partial frame
    send(32'h50, 3);
    check("to_fill3", JW'(fill_level), JW'(3));
    pulses = 0;
    pulse_at = -1;
    for (int i = 1; i <= TO + 5; i++) begin
      tick();
      if (i == TO - 1) check("to_fill_before", JW'(fill_level), JW'(3));
      if (frame_err) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("to_pulses", JW'(pulses), JW'(1));
    check("to_pulse_at", JW'(pulse_at), JW'(TO));
    check("to_fill0", JW'(fill_level), JW'(0));
    send(32'hA0, WORDS);
    check("to_job_valid", JW'(job_valid), JW'(1));
    check("to_word0", JW'(job_data[31:0]), JW'(32'hA0));
    check("to_job", job_data, make_job(32'hA0));
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;

    // a word on the expiry cycle wins over the timeout
    send(32'hB0, 1);
    pulses = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (frame_err) pulses++;
    end
    send(32'hB1, 1);
    check("ex_frame_err", JW'(frame_err), JW'(0));
    check("ex_fill", JW'(fill_level), JW'(2));
    tick();
    check("ex_frame_err_after", JW'(frame_err), JW'(0));
    check("ex_pulses", JW'(pulses), JW'(0));
`else
    // without the timeout a partial frame waits indefinitely
    send(32'h200, 3);
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (frame_err) pulses++;
    end
    check("nt_pulses", JW'(pulses), JW'(0));
    check("nt_fill", JW'(fill_level), JW'(3));
    send(32'h203, 8);
    exp_job = make_job(32'h200);
    check("nt_job_valid", JW'(job_valid), JW'(1));
    check("nt_job", job_data, exp_job);
    check("nt_frame_err", JW'(frame_err), JW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
